usb1_line_cond: RTL
===================

USB1_LINE_COND -- requirements
Module: usb1_line_cond

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning pad synchronizer depth (min 2).
REQ-002 SHALL have parameter GLITCH_CYC, default 3, meaning cycles a new pad pair must stay stable before it is accepted.
REQ-003 SHALL have parameter DISC_CYC, default 120, meaning SE0 length in cycles that declares disconnect (2.5 us at 48 MHz).
REQ-004 SHALL have parameter CONN_CYC, default 4800, meaning idle non-SE0 length in cycles that declares connect (100 us at 48 MHz).
REQ-005 SHALL use one clock and a synchronous, active-low reset: usb_clk_i  input  1  48 MHz USB clock.
REQ-006 SHALL have port usb_rstn_i  input  1  synchronous active-low reset.
REQ-007 SHALL have port in_dp  input  1  raw asynchronous D+ pad.
REQ-008 SHALL have port in_dn  input  1  raw asynchronous D- pad.
REQ-009 SHALL have port tx_oen_i  input  1  PHY output enable (1 = receiving, 0 = host driving).
REQ-010 SHALL have port rx_dp_o  output  1  conditioned D+ to PHY.
REQ-011 SHALL have port rx_dn_o  output  1  conditioned D- to PHY.
REQ-012 SHALL have port rx_rcv_o  output  1  differential receive bit to PHY.
REQ-013 SHALL have port linestate_o  output  2  {dn,dp}: 00 SE0, 01 J(FS), 10 K(FS), 11 SE1.
REQ-014 SHALL have port conn_o  output  1  device attached.
REQ-015 SHALL have port fs_o  output  1  full-speed device, latched at connect.
REQ-016 SHALL have port conn_pulse_o  output  1  one-cycle connect event.
REQ-017 SHALL have port disc_pulse_o  output  1  one-cycle disconnect event.

Function
REQ-018 SHALL pass in_dp/in_dn through SYNC_STAGES flops; no other logic precedes the synchronizer.
REQ-019 SHALL update filtered pair only after the synchronized pair differs from it and holds one value for GLITCH_CYC consecutive cycles; a shorter pulse is discarded and restarts the stability count.
REQ-020 SHALL make a stable pad change visible on rx_dp_o/rx_dn_o/linestate_o exactly SYNC_STAGES+GLITCH_CYC cycles after the first clock edge that samples it.
REQ-021 SHALL drive rx_rcv_o = filtered dp, holding its previous value while filtered pair is SE0 or SE1.
REQ-022 SHALL implement FSM DISC -> CONNING -> CONN; DISC leaves on filtered J or K with tx_oen_i=1.
REQ-023 SHALL in CONNING count cycles of stable non-SE0, non-SE1 line; SE0/SE1 returns to DISC with count cleared; count reaching CONN_CYC enters CONN, sets conn_o, pulses conn_pulse_o, latches fs_o = filtered dp.
REQ-024 SHALL in CONN count consecutive SE0 cycles with tx_oen_i=1; any non-SE0 or tx_oen_i=0 clears it; reaching DISC_CYC enters DISC, clears conn_o and fs_o, pulses disc_pulse_o.
REQ-025 SHALL never treat EOP (SE0 < DISC_CYC) or host-driven bus reset (tx_oen_i=0) as disconnect.
REQ-026 SHALL size the counter $clog2(CONN_CYC+1) bits, saturating, shared between CONNING and CONN.
REQ-027 SHALL never assert conn_pulse_o and disc_pulse_o in the same cycle.

Reset
REQ-028 SHALL on usb_rstn_i=0 at a clock edge clear synchronizer, filter, and counter; set rx_dp_o=0, rx_dn_o=0, rx_rcv_o=0, linestate_o=00, conn_o=0, fs_o=0, both pulses 0; FSM=DISC.
REQ-029 SHALL abort any count in progress on reset without emitting a pulse.

Configuration
REQ-030 SHALL compile glitch filter only under USB1_LINE_GLITCH_FILTER_EN; when undefined, filtered pair equals synchronized pair and latency is SYNC_STAGES cycles; FSM behaviour is otherwise unchanged.

Structure
REQ-031 SHALL place linestate typedef (SE0/J/K/SE1), FSM state enum, and default timing constants in package usb1_line_pkg.
REQ-032 SHALL instantiate one sub-module usb1_line_glitch (stability counter plus filtered register, 2-bit data).

Verification
REQ-033 SHALL test reset: hold usb_rstn_i=0 with pads 01 for 10 cycles -> all outputs 0, FSM=DISC.
REQ-034 SHALL test glitch: pad pair 01 stable, 2-cycle 00 pulse -> linestate_o stays 01; 3-cycle pulse -> 00 exactly 5 cycles after the first sample (filter on).
REQ-035 SHALL test connect: pads go 01 at t0 -> conn_pulse_o one cycle at t0+5+4800, fs_o=1; pads 10 -> fs_o=0.
REQ-036 SHALL test EOP versus disconnect: in CONN, SE0 for 8 cycles -> no disc_pulse_o; SE0 for 125 cycles -> disc_pulse_o once, conn_o=0.
REQ-037 SHALL test host reset: tx_oen_i=0 with SE0 for 500 cycles -> conn_o stays 1.
REQ-038 SHALL test mid-count reset: usb_rstn_i=0 at cycle 2000 of CONNING -> no pulse, connect needs full 4800 after release.

Source files
------------

// File: rtl/usb1_line_pkg.sv
// usb1_line_pkg
//   Shared types and default timing for the USB 1.x line conditioner.
//   - linestate_t   : {dn,dp} bus state (SE0, J, K, SE1) in full-speed terms
//   - conn_state_t  : attach-detect state machine encoding
//   - DEF_*         : default synchronizer depth, glitch window and
//                     connect/disconnect times in 48 MHz clock cycles
package usb1_line_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } linestate_t;

  typedef enum logic [1:0] {
    ST_DISC    = 2'b00,
    ST_CONNING = 2'b01,
    ST_CONN    = 2'b10
  } conn_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GLITCH_CYC  = 3;
  localparam int DEF_DISC_CYC    = 120;   // 2.5 us of SE0
  localparam int DEF_CONN_CYC    = 4800;  // 100 us of idle

endpackage

// File: rtl/usb1_line_glitch.sv
// usb1_line_glitch
//   Stability filter for the synchronized 2-bit pad pair. The output only
//   moves to a new value after the input has differed from the output and
//   held that same value for GLITCH_CYC consecutive cycles; anything shorter
//   is dropped and the count starts over.
//   Optional feature macro: USB1_LINE_GLITCH_FILTER_EN. Without it the
//   module is a plain wire (q = d) and adds no latency.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   d      : synchronized pad pair {dn,dp}
//   q      : filtered pad pair {dn,dp}
module usb1_line_glitch
  import usb1_line_pkg::*;
#(
  parameter int GLITCH_CYC = DEF_GLITCH_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

`ifdef USB1_LINE_GLITCH_FILTER_EN
  localparam int CW = $clog2(GLITCH_CYC + 1);

  logic [1:0]    q_reg, q_next;
  logic [1:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    q_next    = q_reg;
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    if (d == q_reg) begin
      cnt_next = '0;
    end else begin
      cand_next = d;
      // A zero count means the previous sample matched the output, so even
      // a leftover candidate equal to d is the start of a fresh run.
      if (d == cand_reg && cnt_reg != '0) begin
        cnt_next = cnt_reg + 1'b1;
      end else begin
        cnt_next = CW'(1);
      end
      if (cnt_next == CW'(GLITCH_CYC)) begin
        q_next   = d;
        cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg    <= '0;
      cand_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      q_reg    <= q_next;
      cand_reg <= cand_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign q = q_reg;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, GLITCH_CYC};
  assign q = d;
`endif

endmodule

// File: rtl/usb1_line_cond.sv
// usb1_line_cond
//   Conditions the raw USB 1.x D+/D- pads for the PHY and detects device
//   attach/detach. Pads pass through a SYNC_STAGES flop synchronizer, an
//   optional stability filter (macro USB1_LINE_GLITCH_FILTER_EN), and a
//   registered output stage. A three-state machine (DISC/CONNING/CONN)
//   declares connect after CONN_CYC cycles of idle J/K and disconnect after
//   DISC_CYC cycles of SE0 while the PHY is receiving.
// Ports:
//   usb_clk_i    : 48 MHz USB clock
//   usb_rstn_i   : synchronous active-low reset
//   in_dp/in_dn  : raw asynchronous pads
//   tx_oen_i     : 1 = PHY receiving, 0 = host driving the bus
//   rx_dp_o/rx_dn_o/linestate_o : conditioned line ({dn,dp})
//   rx_rcv_o     : differential receive bit (holds through SE0/SE1)
//   conn_o/fs_o  : attached flag and full-speed flag latched at connect
//   conn_pulse_o/disc_pulse_o : one-cycle attach/detach events
module usb1_line_cond
  import usb1_line_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int GLITCH_CYC  = DEF_GLITCH_CYC,
  parameter int DISC_CYC    = DEF_DISC_CYC,
  parameter int CONN_CYC    = DEF_CONN_CYC
) (
  input  logic       usb_clk_i,
  input  logic       usb_rstn_i,
  input  logic       in_dp,
  input  logic       in_dn,
  input  logic       tx_oen_i,
  output logic       rx_dp_o,
  output logic       rx_dn_o,
  output logic       rx_rcv_o,
  output logic [1:0] linestate_o,
  output logic       conn_o,
  output logic       fs_o,
  output logic       conn_pulse_o,
  output logic       disc_pulse_o
);

  localparam int CNT_W = $clog2(CONN_CYC + 1);
  localparam logic [CNT_W-1:0] CONN_LIM = CNT_W'(CONN_CYC);
  localparam logic [CNT_W-1:0] DISC_LIM = CNT_W'(DISC_CYC);

  // Synchronizer: newest sample enters at the low pair, oldest leaves high.
  logic [2*SYNC_STAGES-1:0] sync_reg;
  logic [1:0]               sync_last;
  logic [1:0]               filt;

  always_ff @(posedge usb_clk_i) begin
    if (!usb_rstn_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[2*SYNC_STAGES-3:0], in_dn, in_dp};
    end
  end

  assign sync_last = sync_reg[2*SYNC_STAGES-1 -: 2];

  usb1_line_glitch #(
    .GLITCH_CYC(GLITCH_CYC)
  ) u_glitch (
    .clk   (usb_clk_i),
    .rst_n (usb_rstn_i),
    .d     (sync_last),
    .q     (filt)
  );

  // Output stage; rx_rcv only follows differential states.
  linestate_t line_reg;
  logic       rcv_reg;

  always_ff @(posedge usb_clk_i) begin
    if (!usb_rstn_i) begin
      line_reg <= LS_SE0;
      rcv_reg  <= 1'b0;
    end else begin
      line_reg <= linestate_t'(filt);
      if (filt == LS_J || filt == LS_K) begin
        rcv_reg <= filt[0];
      end
    end
  end

  // Attach detection works on the registered line so that the connect and
  // disconnect timing lines up with what the PHY sees on linestate_o.
  conn_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             conn_reg, conn_next;
  logic             fs_reg, fs_next;
  logic             conn_pulse_reg, conn_pulse_next;
  logic             disc_pulse_reg, disc_pulse_next;

  assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    conn_next       = conn_reg;
    fs_next         = fs_reg;
    conn_pulse_next = 1'b0;
    disc_pulse_next = 1'b0;
    case (state_reg)
      ST_DISC: begin
        cnt_next = '0;
        if ((line_reg == LS_J || line_reg == LS_K) && tx_oen_i) begin
          state_next = ST_CONNING;
          cnt_next   = CNT_W'(1);  // the qualifying cycle counts as the first
        end
      end
      ST_CONNING: begin
        if (line_reg == LS_SE0 || line_reg == LS_SE1) begin
          state_next = ST_DISC;
          cnt_next   = '0;
        end else if (cnt_inc >= CONN_LIM) begin
          state_next      = ST_CONN;
          cnt_next        = '0;
          conn_next       = 1'b1;
          fs_next         = line_reg[0];
          conn_pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_CONN: begin
        // Host-driven SE0 (bus reset) and short SE0 (EOP) never detach.
        if (line_reg == LS_SE0 && tx_oen_i) begin
          if (cnt_inc >= DISC_LIM) begin
            state_next      = ST_DISC;
            cnt_next        = '0;
            conn_next       = 1'b0;
            fs_next         = 1'b0;
            disc_pulse_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          cnt_next = '0;
        end
      end
      default: begin
        state_next = ST_DISC;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge usb_clk_i) begin
    if (!usb_rstn_i) begin
      state_reg      <= ST_DISC;
      cnt_reg        <= '0;
      conn_reg       <= 1'b0;
      fs_reg         <= 1'b0;
      conn_pulse_reg <= 1'b0;
      disc_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      conn_reg       <= conn_next;
      fs_reg         <= fs_next;
      conn_pulse_reg <= conn_pulse_next;
      disc_pulse_reg <= disc_pulse_next;
    end
  end

  assign rx_dp_o      = line_reg[0];
  assign rx_dn_o      = line_reg[1];
  assign linestate_o  = line_reg;
  assign rx_rcv_o     = rcv_reg;
  assign conn_o       = conn_reg;
  assign fs_o         = fs_reg;
  assign conn_pulse_o = conn_pulse_reg;
  assign disc_pulse_o = disc_pulse_reg;

endmodule
